// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked ripple-carry add/subtract pipeline with per-stage valid/ready handshake
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  logic [STAGES-1:0] v_q, v_d, adv;
  logic [STAGES:0] rdy;
  logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
  logic [WIDTH-1:0] a_in [STAGES], b_in [STAGES], s_in [STAGES], s_d [STAGES];
  logic c_q [STAGES], c_in [STAGES], c_d [STAGES];
  logic [CW:0] t;
  logic ovf_q, ovf_d;
  // ready ripples back from the consumer; an empty stage always accepts
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
    adv[0] = in_valid & rdy[0];
    for (int k = 1; k < STAGES; k++) adv[k] = v_q[k-1] & rdy[k];
    for (int k = 0; k < STAGES; k++) v_d[k] = adv[k] | (v_q[k] & ~rdy[k+1]);
  end
  // each stage adds its own chunk using the carry handed over by the stage before it
  always_comb begin
    a_in[0] = a;
    b_in[0] = b ^ {WIDTH{sub}};
    s_in[0] = '0;
    c_in[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
    end
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]} + {{CW{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*CW +: CW] = t[CW-1:0];
      c_d[k] = t[CW];
    end
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &
            (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end
  // stage registers load only when a beat advances into them, so a stalled output holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (adv[STAGES-1]) ovf_q <= ovf_d;
    end
  end
  assign in_ready = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed checks of the pipelined add/subtract unit at 8x2 and 16x4
module tb_pipelined_addsub;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b1, co8, of8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic v16 = 1'b0, ir16, s16 = 1'b0, ov16, or16 = 1'b0, co16, of16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  int n_cmp = 0, n_err = 0, acc = 0, got = 0, lim = 0;
  logic sawv;
  vec_t t8 [13] = '{
    '{16'd0,   16'd0,   1'b0, 16'd0,   1'b0, 1'b0},
    '{16'd5,   16'd10,  1'b0, 16'd15,  1'b0, 1'b0},
    '{16'd255, 16'd1,   1'b0, 16'd0,   1'b1, 1'b0},
    '{16'd128, 16'd127, 1'b0, 16'd255, 1'b0, 1'b0},
    '{16'd100, 16'd200, 1'b0, 16'd44,  1'b1, 1'b0},
    '{16'd100, 16'd100, 1'b0, 16'd200, 1'b0, 1'b1},
    '{16'd5,   16'd10,  1'b1, 16'd251, 1'b0, 1'b0},
    '{16'd10,  16'd5,   1'b1, 16'd5,   1'b1, 1'b0},
    '{16'd128, 16'd1,   1'b1, 16'd127, 1'b1, 1'b1},
    '{16'd200, 16'd50,  1'b0, 16'd250, 1'b0, 1'b0},
    '{16'd200, 16'd50,  1'b1, 16'd150, 1'b1, 1'b0},
    '{16'd3,   16'd7,   1'b0, 16'd10,  1'b0, 1'b0},
    '{16'd3,   16'd7,   1'b1, 16'd252, 1'b0, 1'b0}
  };
  vec_t t16 [10] = '{
    '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0},
    '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0},
    '{16'hABCD, 16'h1234, 1'b1, 16'h9999, 1'b1, 1'b0},
    '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0}
  };
  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8), .sub(s8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .ovf(of8)
  );
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .a(a16), .b(b16), .sub(s16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(co16), .ovf(of16)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive16();
    v16 = acc < lim;
    if (acc < lim) begin
      a16 = t16[acc].a;
      b16 = t16[acc].b;
      s16 = t16[acc].sub;
    end
  endtask
  task automatic cycle16();
    @(negedge clk);
    if (v16 && ir16) acc++;
    if (ov16 && or16) begin
      n_cmp++;
      assert (got < 10) else begin
        n_err++;
        $error("FAIL extra16: observed beat %0d expected at most %0d", got, 9);
      end
      if (got < 10) begin
        chk($sformatf("sum16_%0d", got), sum16, t16[got].s);
        chk($sformatf("cout16_%0d", got), co16, t16[got].c);
        chk($sformatf("ovf16_%0d", got), of16, t16[got].o);
      end
      got++;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov8", ov8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_ovf8", of8, 0);
    chk("rst_ov16", ov16, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ir8", ir8, 1);
    chk("rst_ir16", ir16, 1);
    for (int i = 0; i <= 13; i++) begin
      v8 = i < 13;
      if (i < 13) begin
        a8 = t8[i].a[7:0];
        b8 = t8[i].b[7:0];
        s8 = t8[i].sub;
        chk($sformatf("ir8_%0d", i), ir8, 1);
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        chk($sformatf("ov8_%0d", i - 1), ov8, 1);
        chk($sformatf("sum8_%0d", i - 1), sum8, t8[i-1].s[7:0]);
        chk($sformatf("cout8_%0d", i - 1), co8, t8[i-1].c);
        chk($sformatf("ovf8_%0d", i - 1), of8, t8[i-1].o);
      end
    end
    @(posedge clk);
    #1;
    chk("ov8_drained", ov8, 0);
    lim = 6;
    drive16();
    repeat (6) begin
      cycle16();
      drive16();
    end
    chk("bp_acc", acc, 4);
    chk("bp_ir", ir16, 0);
    chk("bp_ov", ov16, 1);
    chk("bp_sum", sum16, 16'h2345);
    repeat (2) begin
      cycle16();
      drive16();
    end
    chk("bp_hold_sum", sum16, 16'h2345);
    chk("bp_hold_acc", acc, 4);
    or16 = 1'b1;
    #1;
    chk("bp_ir_release", ir16, 1);
    for (int t = 0; t < 40 && got < 6; t++) begin
      cycle16();
      drive16();
    end
    chk("bp_got", got, 6);
    chk("bp_acc_all", acc, 6);
    or16 = 1'b0;
    lim = 7;
    drive16();
    repeat (3) begin
      cycle16();
      drive16();
    end
    lim = 8;
    drive16();
    repeat (3) begin
      cycle16();
      drive16();
    end
    chk("bub_acc", acc, 8);
    chk("bub_ov", ov16, 1);
    chk("bub_sum", sum16, 16'h0003);
    lim = 10;
    drive16();
    chk("bub_ir_a", ir16, 1);
    cycle16();
    drive16();
    chk("bub_ir_b", ir16, 1);
    cycle16();
    drive16();
    chk("bub_acc_full", acc, 10);
    chk("bub_ir_full", ir16, 0);
    or16 = 1'b1;
    #1;
    for (int t = 0; t < 40 && got < 10; t++) begin
      cycle16();
      drive16();
    end
    chk("bub_got", got, 10);
    or16 = 1'b0;
    v16 = 1'b1;
    a16 = 16'h1111;
    b16 = 16'h2222;
    s16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v16 = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ov_pre", ov16, 1);
    chk("mid_sum_pre", sum16, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ov", ov16, 0);
    chk("mid_sum", sum16, 0);
    chk("mid_cout", co16, 0);
    chk("mid_ovf", of16, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_ir", ir16, 1);
    or16 = 1'b1;
    sawv = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ov16) sawv = 1'b1;
    end
    chk("mid_stale", sawv, 0);
    v16 = 1'b1;
    a16 = 16'hFFFF;
    b16 = 16'h0001;
    s16 = 1'b0;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_ov", ov16, 1);
    chk("post_sum", sum16, 16'h0000);
    chk("post_cout", co16, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined add/subtract unit that succeeds the fixed 8-bit registered adder. Operand width and pipeline depth are set by parameters. The carry ripples one chunk per stage, and each stage has its own valid/ready handshake with bubble collapsing and downstream backpressure. The unit sits between an operand producer and a result consumer in the datapath and reports carry-out and signed overflow alongside the sum.

## Interface
- WIDTH, 16, operand and sum width in bits; must be at least 2 and an exact multiple of STAGES.
- STAGES, 4, number of pipeline stages; the chunk width is CW = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand beat is present.
- in_ready  output  1  stage 0 can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  selects the operation: 0 gives A+B, 1 gives A-B.
- out_valid  output  1  result beat is present.
- out_ready  input  1  consumer accepts the result beat.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of the MSB. For sub this is the no-borrow flag (1 when A >= B unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Arithmetic is A + (B XOR {WIDTH{sub}}) + sub, computed in CW-bit chunks.
- Stage k (0..STAGES-1) registers the following:
  - sum chunk k;
  - the carry out of chunk k;
  - the untouched upper operand chunks (already inverted when sub=1);
  - the sub bit;
  - the sign bits of A and modified B;
  - a valid bit v[k].
- Stage 0 uses carry-in = sub. Stage k uses the carry registered by stage k-1.
- Final stage outputs:
  - sum is the concatenation of all chunks;
  - cout is the carry out of chunk STAGES-1;
  - ovf = (signA == signB') AND (sum[WIDTH-1] != signA), where B' is the modified B.
- Handshake:
  - Stage k advances when v[k-1] AND (NOT v[k] OR advance of stage k+1). Stage 0 advances on in_valid AND in_ready.
  - The final stage's downstream condition is out_ready.
  - in_ready = NOT v[0] OR (v[0] AND stage 1 advances).
  - Ready is combinational back through the chain; there are no skid buffers.
- Bubbles collapse: an empty stage always accepts, even while the output is stalled.
- A transfer occurs on a rising edge where valid AND ready are both high.
- out_valid = v[STAGES-1]. sum, cout and ovf are driven straight from the final-stage registers.
- While out_valid=1 and out_ready=0, sum, cout and ovf must hold stable.
- Data registers of invalid stages may hold stale values. Only the valid bits require reset.

## Timing
- On reset assertion (rst_n low), asynchronously and immediately:
  - all v[k] go to 0, so out_valid=0;
  - sum = 0, cout = 0, ovf = 0;
  - in_ready = 1 once reset is released.
- Latency: a beat accepted at rising edge N appears with out_valid=1 after edge N+STAGES-1, assuming no stalls. Example: STAGES=1 gives out_valid in the cycle following the accepting edge.
- Throughput: 1 beat per cycle with out_ready held high.
- Capacity: STAGES beats in flight. When all stages are valid and out_ready=0, in_ready=0.
- A full pipe with out_ready going high accepts a new beat on the same edge the output beat leaves.
- Reset asserted mid-operation discards all in-flight beats. No partial result is emitted after reset releases.
- sub is sampled with the operands and travels with its beat. Mixing add and sub in consecutive beats is legal.

## Test plan
- Reset checks (WIDTH=8, STAGES=2):
  - hold rst_n=0 -> out_valid=0, sum=0, cout=0, ovf=0;
  - release reset -> in_ready=1.
- Back-to-back adds (WIDTH=8, STAGES=2, out_ready=1), beats (0,0), (5,10), (255,1), (128,127), (100,200), (100,100). Each beat must come out 2 cycles later, in order:
  - (0,0) -> sum=0, cout=0, ovf=0;
  - (5,10) -> sum=15, cout=0, ovf=0;
  - (255,1) -> sum=0, cout=1, ovf=0;
  - (128,127) -> sum=255, cout=0, ovf=0;
  - (100,200) -> sum=44, cout=1, ovf=0;
  - (100,100) -> sum=200, cout=0, ovf=1.
- Subtract (WIDTH=8, STAGES=2):
  - 5-10 -> sum=251, cout=0, ovf=0;
  - 10-5 -> sum=5, cout=1;
  - 128-1 -> sum=127, ovf=1;
  - alternate sub=0/1 every beat -> each result matches its own sub bit.
- Backpressure (WIDTH=16, STAGES=4):
  - hold out_ready=0 while driving 6 beats -> exactly 4 accepted, then in_ready=0, and sum holds stable;
  - raise out_ready -> all 6 results emerge in order, none lost or duplicated.
- Bubble collapse (WIDTH=16, STAGES=4):
  - send a beat, idle 2 cycles, send a beat, with out_ready=0 -> both beats are accepted and sit in stages 3 and 2;
  - then in_ready stays 1 for 2 more beats.
- Reset mid-flight (WIDTH=16, STAGES=4):
  - with 3 beats in flight, pulse rst_n low between clock edges -> out_valid=0 immediately;
  - after release, no stale result appears;
  - the next beat 0xFFFF+0x0001 -> sum=0x0000, cout=1.
